paillier_task_scheduler: RTL and testbench
==========================================

Name: paillier_task_scheduler

Overview:
- Sits between the AXI-Lite command register file and the BLOCK_COUNT parallel Paillier engines inside the AXI top.
- Buffers task descriptors (mode, source and destination addresses, ID) in a FIFO.
- Dispatches each task to an idle engine using round-robin arbitration.
- Collects engine completions and returns them one per handshake, tagged with task ID and engine index.

Parameters:
- BLOCK_COUNT, 4, number of engines (1..16).
- QUEUE_DEPTH, 8, task FIFO entries (power of 2, ≥2).
- ID_W, 8, task ID width.
- ADDR_W, 64, address width.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  reset
- enable  in  1  dispatch enable; queue still accepts tasks when low
- flush  in  1  one-cycle pulse, empties the queue
- task_valid  in  1  descriptor valid
- task_ready  out  1  queue can accept a descriptor
- task_mode  in  2  00 encryption, 01 decryption, 10 homomorphic add, 11 scalar mul
- task_src_addr  in  ADDR_W  operand base address
- task_dst_addr  in  ADDR_W  result base address
- task_id  in  ID_W  tag
- eng_start  out  BLOCK_COUNT  one-hot, one-cycle start pulse
- eng_mode  out  2  mode for the engine being started
- eng_src_addr  out  ADDR_W  source address for the engine being started
- eng_dst_addr  out  ADDR_W  destination address for the engine being started
- eng_done  in  BLOCK_COUNT  per-engine completion pulse
- cpl_valid  out  1  completion available
- cpl_ready  in  1  completion accepted
- cpl_id  out  ID_W  ID of the completed task
- cpl_engine  out  4  index of the engine that completed it
- queue_level  out  $clog2(QUEUE_DEPTH)+1  occupancy
- inflight  out  BLOCK_COUNT  reserved-engine mask
- idle  out  1  queue empty, no engine reserved, no completion pending
- err_sticky  out  1  done received from an unreserved engine

Behaviour:
- Reset: M_AXI_ARESETN, asynchronous, active-high. It clears the FIFO, the reserved and pending masks, both round-robin pointers and err_sticky. Reset values: eng_start=0, cpl_valid=0, task_ready=0 while in reset and 1 on the first cycle after. All data outputs are 0; idle=1.
- Reset mid-operation: everything listed above is dropped. Engines must be reset by the same signal.
- Queue:
  - task_ready = (count < QUEUE_DEPTH). A push occurs on task_valid && task_ready.
  - No bypass: a pop at full does not raise task_ready in the same cycle.
  - Pointers wrap modulo QUEUE_DEPTH.
- Dispatch (registered, at most one per cycle):
  - Eligible engines are those with reserved=0 and pending=0, taken from registered state.
  - When enable && count>0 && any engine is eligible, choose the first eligible index at or after rr_disp, wrapping.
  - In that same cycle: pop the head entry, set reserved[i], store the ID in id_reg[i], and set rr_disp=i+1 mod BLOCK_COUNT.
  - eng_start[i] and the eng_* fields are registered outputs, valid for one cycle only. Latency is task accepted at cycle N, earliest eng_start at N+1.
  - eng_* fields are 0 when no start is issued.
- Completion:
  - eng_done[i] with reserved[i]=1 clears reserved[i] and sets pending[i].
  - eng_done[i] with reserved[i]=0 is ignored and sets err_sticky (cleared only by reset).
  - Multiple dones in the same cycle are all captured.
  - An engine with pending=1 is not re-dispatched until its completion is accepted.
- Completion output:
  - When cpl_valid=0 and pending≠0, select the first pending index at or after rr_cpl, then drive cpl_valid=1, cpl_id=id_reg[i] and cpl_engine=i on the next cycle.
  - Outputs hold stable until cpl_ready. On handshake: clear pending[i], set rr_cpl=i+1, cpl_valid=0 for at least one cycle.
- Simultaneous events:
  - Done and dispatch in the same cycle: the freed engine is not a candidate until the following cycle's arbitration and completion acceptance.
  - flush together with push: flush wins and the pushed entry is discarded.
  - flush does not affect reserved or pending engines.
- enable low: no new eng_start. In-flight tasks and the completion path continue normally.
- idle = (count==0) && reserved==0 && pending==0 && !cpl_valid.

Test Plan:
- Reset, enable=1, push ID 0x11 mode 00 src 0x1000 dst 0x2000 at cycle 10 → eng_start=0001 at cycle 11 with fields matching. eng_done[0] pulse → cpl_valid with cpl_id=0x11, cpl_engine=0; cpl_ready → idle=1.
- enable=0, push 9 descriptors → task_ready falls after the 8th, queue_level=8, 9th not accepted. Raise enable → starts on engines 0,1,2,3 in consecutive cycles, queue_level=4.
- All 4 engines reserved; eng_done=1010 in the same cycle → two completions, engine 1 then engine 3, each held until cpl_ready. Their reserved bits are clear and pending bits hold until acceptance. The next two queued tasks go to engines 1 and 3 only after the respective completions are accepted.
- eng_done[2] with inflight=0 → err_sticky=1, no cpl_valid. Sticky until reset.
- 5 tasks queued, 2 in flight, flush → queue_level=0. The 2 in-flight tasks still complete with the correct IDs.
- Assert reset mid-run with 3 queued and 2 in flight → all outputs return to reset values within the same cycle (asynchronous). After release, task_ready=1 and idle=1.

Source files
------------

// File: rtl/paillier_task_scheduler.sv
// Paillier task scheduler: queues task descriptors, hands each one to an idle
// engine in round-robin order and returns the completions one at a time,
// tagged with the task ID and the engine index.
//
// state            | meaning
// reserved[i]=1    | engine i has been started and has not reported done yet
// pending[i]=1     | engine i reported done; its completion is not yet accepted
// cpl_valid=1      | a completion is presented on cpl_* and held until cpl_ready
module paillier_task_scheduler #(
    parameter int BLOCK_COUNT = 4,
    parameter int QUEUE_DEPTH = 8,
    parameter int ID_W        = 8,
    parameter int ADDR_W      = 64
) (
    input  logic                             M_AXI_ACLK,
    input  logic                             M_AXI_ARESETN,
    input  logic                             enable,
    input  logic                             flush,
    input  logic                             task_valid,
    output logic                             task_ready,
    input  logic [1:0]                       task_mode,
    input  logic [ADDR_W-1:0]                task_src_addr,
    input  logic [ADDR_W-1:0]                task_dst_addr,
    input  logic [ID_W-1:0]                  task_id,
    output logic [BLOCK_COUNT-1:0]           eng_start,
    output logic [1:0]                       eng_mode,
    output logic [ADDR_W-1:0]                eng_src_addr,
    output logic [ADDR_W-1:0]                eng_dst_addr,
    input  logic [BLOCK_COUNT-1:0]           eng_done,
    output logic                             cpl_valid,
    input  logic                             cpl_ready,
    output logic [ID_W-1:0]                  cpl_id,
    output logic [3:0]                       cpl_engine,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_level,
    output logic [BLOCK_COUNT-1:0]           inflight,
    output logic                             idle,
    output logic                             err_sticky
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [1:0]             mode_mem [QUEUE_DEPTH];
    logic [ADDR_W-1:0]      src_mem  [QUEUE_DEPTH];
    logic [ADDR_W-1:0]      dst_mem  [QUEUE_DEPTH];
    logic [ID_W-1:0]        id_mem   [QUEUE_DEPTH];

    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;

    logic [BLOCK_COUNT-1:0] reserved;
    logic [BLOCK_COUNT-1:0] pending;
    logic [3:0]             rr_disp;
    logic [3:0]             rr_cpl;
    logic [ID_W-1:0]        id_reg [BLOCK_COUNT];

    logic                   push;
    logic                   pop;
    logic                   disp;
    logic                   disp_found;
    logic [3:0]             disp_idx;
    logic [BLOCK_COUNT-1:0] disp_onehot;
    logic [BLOCK_COUNT-1:0] eligible;
    logic                   cpl_found;
    logic [3:0]             cpl_idx;
    logic                   cpl_fire;
    logic [BLOCK_COUNT-1:0] cpl_clear;
    logic [BLOCK_COUNT-1:0] done_ok;
    logic [BLOCK_COUNT-1:0] done_bad;

    // First requester at or after ptr, wrapping; returns {found, index}.
    function automatic logic [4:0] rr_pick(input logic [BLOCK_COUNT-1:0] req,
                                           input logic [3:0] ptr);
        logic [4:0] res;
        int j;
        res = '0;
        for (int k = 0; k < BLOCK_COUNT; k++) begin
            j = (int'(ptr) + k) % BLOCK_COUNT;
            if (!res[4] && ((req >> j) & BLOCK_COUNT'(1)) != '0)
                res = {1'b1, 4'(j)};
        end
        return res;
    endfunction

    // Arbitration and queue bookkeeping, all from registered state.
    always_comb begin
        push                    = task_valid && task_ready && !flush;
        eligible                = ~reserved & ~pending;
        {disp_found, disp_idx}  = rr_pick(eligible, rr_disp);
        // Flush takes the queue away, so nothing is started in that cycle.
        disp                    = enable && !flush && (count != '0) && disp_found;
        pop                     = disp;
        disp_onehot             = disp ? (BLOCK_COUNT'(1) << disp_idx) : '0;
        {cpl_found, cpl_idx}    = rr_pick(pending, rr_cpl);
        cpl_fire                = cpl_valid && cpl_ready;
        cpl_clear               = cpl_fire ? (BLOCK_COUNT'(1) << cpl_engine) : '0;
        done_ok                 = eng_done & reserved;
        done_bad                = eng_done & ~reserved;
        if (flush)
            count_next = '0;
        else
            count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Descriptor storage; contents need no reset since count gates every read.
    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            mode_mem[wr_ptr] <= task_mode;
            src_mem[wr_ptr]  <= task_src_addr;
            dst_mem[wr_ptr]  <= task_dst_addr;
            id_mem[wr_ptr]   <= task_id;
        end
    end

    // Queue pointers, engine reservation, dispatch and completion outputs.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            task_ready   <= 1'b0;
            reserved     <= '0;
            pending      <= '0;
            rr_disp      <= '0;
            rr_cpl       <= '0;
            err_sticky   <= 1'b0;
            eng_start    <= '0;
            eng_mode     <= '0;
            eng_src_addr <= '0;
            eng_dst_addr <= '0;
            cpl_valid    <= 1'b0;
            cpl_id       <= '0;
            cpl_engine   <= '0;
            for (int i = 0; i < BLOCK_COUNT; i++)
                id_reg[i] <= '0;
        end else begin
            count      <= count_next;
            // Registered so a pop at full cannot reopen the queue combinationally.
            task_ready <= (count_next < CNT_W'(QUEUE_DEPTH));

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            // A dispatched engine was unreserved, so done_ok never hits it.
            reserved   <= (reserved | disp_onehot) & ~done_ok;
            pending    <= (pending | done_ok) & ~cpl_clear;
            err_sticky <= err_sticky | (|done_bad);

            eng_start <= disp_onehot;
            if (disp) begin
                eng_mode     <= mode_mem[rd_ptr];
                eng_src_addr <= src_mem[rd_ptr];
                eng_dst_addr <= dst_mem[rd_ptr];
                rr_disp      <= 4'((int'(disp_idx) + 1) % BLOCK_COUNT);
                for (int i = 0; i < BLOCK_COUNT; i++)
                    if (disp_onehot[i]) id_reg[i] <= id_mem[rd_ptr];
            end else begin
                eng_mode     <= '0;
                eng_src_addr <= '0;
                eng_dst_addr <= '0;
            end

            // cpl_valid drops for a cycle after each handshake before reselecting.
            if (cpl_fire) begin
                cpl_valid <= 1'b0;
                rr_cpl    <= 4'((int'(cpl_engine) + 1) % BLOCK_COUNT);
            end else if (!cpl_valid && cpl_found) begin
                cpl_valid  <= 1'b1;
                cpl_engine <= cpl_idx;
                for (int i = 0; i < BLOCK_COUNT; i++)
                    if (cpl_idx == 4'(i)) cpl_id <= id_reg[i];
            end
        end
    end

    assign queue_level = count;
    assign inflight    = reserved;
    assign idle        = (count == '0) && (reserved == '0) && (pending == '0) && !cpl_valid;

endmodule

// File: tb/tb_paillier_task_scheduler.sv
// Directed bench for paillier_task_scheduler: single dispatch, queue fill and
// round-robin start order, simultaneous completions, stray done, flush, and
// asynchronous reset in the middle of traffic.
module tb_paillier_task_scheduler;

    localparam int BC  = 4;
    localparam int QD  = 8;
    localparam int IDW = 8;
    localparam int AW  = 64;

    logic           M_AXI_ACLK = 1'b0;
    logic           M_AXI_ARESETN;
    logic           enable, flush, task_valid, task_ready;
    logic [1:0]     task_mode;
    logic [AW-1:0]  task_src_addr, task_dst_addr;
    logic [IDW-1:0] task_id;
    logic [BC-1:0]  eng_start;
    logic [1:0]     eng_mode;
    logic [AW-1:0]  eng_src_addr, eng_dst_addr;
    logic [BC-1:0]  eng_done;
    logic           cpl_valid, cpl_ready;
    logic [IDW-1:0] cpl_id;
    logic [3:0]     cpl_engine;
    logic [3:0]     queue_level;
    logic [BC-1:0]  inflight;
    logic           idle, err_sticky;

    int errors = 0;
    int checks = 0;

    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    paillier_task_scheduler #(
        .BLOCK_COUNT(BC), .QUEUE_DEPTH(QD), .ID_W(IDW), .ADDR_W(AW)
    ) dut (
        .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESETN(M_AXI_ARESETN),
        .enable(enable), .flush(flush),
        .task_valid(task_valid), .task_ready(task_ready), .task_mode(task_mode),
        .task_src_addr(task_src_addr), .task_dst_addr(task_dst_addr), .task_id(task_id),
        .eng_start(eng_start), .eng_mode(eng_mode),
        .eng_src_addr(eng_src_addr), .eng_dst_addr(eng_dst_addr), .eng_done(eng_done),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id), .cpl_engine(cpl_engine),
        .queue_level(queue_level), .inflight(inflight), .idle(idle), .err_sticky(err_sticky)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge M_AXI_ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        enable = 0; flush = 0; task_valid = 0; task_mode = 0;
        task_src_addr = 0; task_dst_addr = 0; task_id = 0;
        eng_done = 0; cpl_ready = 0;
    endtask

    task automatic do_reset();
        M_AXI_ARESETN = 1;
        clear_inputs();
        tick();
        tick();
        M_AXI_ARESETN = 0;
        tick();
    endtask

    task automatic drive_task(input logic [7:0] k, input logic [7:0] id_base);
        task_valid    = 1;
        task_mode     = k[1:0];
        task_src_addr = 64'h1000 + 64'(k) * 16;
        task_dst_addr = 64'h8000 + 64'(k) * 16;
        task_id       = id_base + k;
    endtask

    // Wait (bounded) for a completion, check it, then accept it.
    task automatic expect_cpl(input logic [7:0] id, input logic [3:0] eng);
        int n = 0;
        while (!cpl_valid && n < 10) begin
            tick();
            n++;
        end
        check("cpl_valid", 64'(cpl_valid), 64'(1));
        check("cpl_id", 64'(cpl_id), 64'(id));
        check("cpl_engine", 64'(cpl_engine), 64'(eng));
        cpl_ready = 1;
        tick();
        cpl_ready = 0;
        check("cpl_drop", 64'(cpl_valid), 64'(0));
    endtask

    initial begin
        clear_inputs();
        M_AXI_ARESETN = 1;
        #12;
        check("rst_ready", 64'(task_ready), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_start", 64'(eng_start), 64'(0));
        check("rst_cpl", 64'(cpl_valid), 64'(0));
        check("rst_level", 64'(queue_level), 64'(0));
        check("rst_err", 64'(err_sticky), 64'(0));
        tick();
        M_AXI_ARESETN = 0;
        tick();
        check("post_rst_ready", 64'(task_ready), 64'(1));

        // single task end to end
        enable = 1;
        task_valid = 1; task_mode = 2'b00; task_id = 8'h11;
        task_src_addr = 64'h1000; task_dst_addr = 64'h2000;
        tick();
        task_valid = 0;
        check("t1_level", 64'(queue_level), 64'(1));
        check("t1_nostart", 64'(eng_start), 64'(0));
        tick();
        check("t1_start", 64'(eng_start), 64'(4'b0001));
        check("t1_mode", 64'(eng_mode), 64'(0));
        check("t1_src", eng_src_addr, 64'h1000);
        check("t1_dst", eng_dst_addr, 64'h2000);
        check("t1_inflight", 64'(inflight), 64'(4'b0001));
        check("t1_level0", 64'(queue_level), 64'(0));
        tick();
        check("t1_pulse", 64'(eng_start), 64'(0));
        check("t1_src0", eng_src_addr, 64'h0);
        eng_done = 4'b0001;
        tick();
        eng_done = 0;
        check("t1_inflight0", 64'(inflight), 64'(0));
        expect_cpl(8'h11, 4'd0);
        check("t1_idle", 64'(idle), 64'(1));

        // fill the queue with dispatch disabled, then release
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive_task(8'(k), 8'h20);
            tick();
            if (k == 7) begin
                check("t2_full_ready", 64'(task_ready), 64'(0));
                check("t2_full_level", 64'(queue_level), 64'(8));
            end
        end
        task_valid = 0;
        check("t2_ninth_level", 64'(queue_level), 64'(8));
        check("t2_nostart", 64'(inflight), 64'(0));
        enable = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t2_start", 64'(eng_start), 64'(1) << k);
            check("t2_src", eng_src_addr, 64'h1000 + 64'(k) * 16);
            check("t2_mode", 64'(eng_mode), 64'(k % 4));
        end
        check("t2_level4", 64'(queue_level), 64'(4));
        check("t2_inflight", 64'(inflight), 64'(4'b1111));
        tick();
        check("t2_nofree", 64'(eng_start), 64'(0));

        // two dones in one cycle, completions and re-dispatch ordering
        eng_done = 4'b1010;
        tick();
        eng_done = 0;
        check("t3_inflight", 64'(inflight), 64'(4'b0101));
        tick();
        check("t3_c1_valid", 64'(cpl_valid), 64'(1));
        check("t3_c1_eng", 64'(cpl_engine), 64'(1));
        check("t3_c1_id", 64'(cpl_id), 64'(8'h21));
        tick();
        check("t3_c1_hold", 64'(cpl_engine), 64'(1));
        check("t3_c1_hold_v", 64'(cpl_valid), 64'(1));
        check("t3_pend_block", 64'(eng_start), 64'(0));
        cpl_ready = 1;
        tick();
        cpl_ready = 0;
        check("t3_c1_drop", 64'(cpl_valid), 64'(0));
        check("t3_c1_nostart", 64'(eng_start), 64'(0));
        tick();
        check("t3_start1", 64'(eng_start), 64'(4'b0010));
        check("t3_start1_src", eng_src_addr, 64'h1040);
        check("t3_c2_valid", 64'(cpl_valid), 64'(1));
        check("t3_c2_eng", 64'(cpl_engine), 64'(3));
        check("t3_c2_id", 64'(cpl_id), 64'(8'h23));
        check("t3_level3", 64'(queue_level), 64'(3));
        tick();
        check("t3_hold3_nostart", 64'(eng_start), 64'(0));
        check("t3_c2_hold", 64'(cpl_engine), 64'(3));
        cpl_ready = 1;
        tick();
        cpl_ready = 0;
        check("t3_c2_drop", 64'(cpl_valid), 64'(0));
        tick();
        check("t3_start3", 64'(eng_start), 64'(4'b1000));
        check("t3_start3_src", eng_src_addr, 64'h1050);
        check("t3_level2", 64'(queue_level), 64'(2));

        // stray done from an unreserved engine
        do_reset();
        enable = 1;
        check("t4_err_clr", 64'(err_sticky), 64'(0));
        eng_done = 4'b0100;
        tick();
        eng_done = 0;
        check("t4_err", 64'(err_sticky), 64'(1));
        tick();
        tick();
        check("t4_nocpl", 64'(cpl_valid), 64'(0));
        check("t4_err_hold", 64'(err_sticky), 64'(1));
        check("t4_idle", 64'(idle), 64'(1));

        // flush with tasks queued and in flight
        do_reset();
        check("t5_err_rst", 64'(err_sticky), 64'(0));
        for (int k = 0; k < 7; k++) begin
            drive_task(8'(k), 8'h50);
            tick();
        end
        task_valid = 0;
        enable = 1;
        tick();
        tick();
        enable = 0;
        tick();
        check("t5_level5", 64'(queue_level), 64'(5));
        check("t5_inflight", 64'(inflight), 64'(4'b0011));
        drive_task(8'h7, 8'h50);
        flush = 1;
        tick();
        flush = 0;
        task_valid = 0;
        check("t5_flush_level", 64'(queue_level), 64'(0));
        check("t5_flush_inflight", 64'(inflight), 64'(4'b0011));
        check("t5_not_idle", 64'(idle), 64'(0));
        eng_done = 4'b0011;
        tick();
        eng_done = 0;
        expect_cpl(8'h50, 4'd0);
        expect_cpl(8'h51, 4'd1);
        check("t5_idle", 64'(idle), 64'(1));

        // asynchronous reset mid-run
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_task(8'(k), 8'h60);
            tick();
        end
        task_valid = 0;
        enable = 1;
        tick();
        tick();
        enable = 0;
        eng_done = 4'b0001;
        tick();
        eng_done = 0;
        tick();
        check("t6_pre_cpl", 64'(cpl_valid), 64'(1));
        check("t6_pre_level", 64'(queue_level), 64'(3));
        #2;
        M_AXI_ARESETN = 1;
        #1;
        check("t6_async_ready", 64'(task_ready), 64'(0));
        check("t6_async_cpl", 64'(cpl_valid), 64'(0));
        check("t6_async_cplid", 64'(cpl_id), 64'(0));
        check("t6_async_level", 64'(queue_level), 64'(0));
        check("t6_async_inflight", 64'(inflight), 64'(0));
        check("t6_async_idle", 64'(idle), 64'(1));
        tick();
        M_AXI_ARESETN = 0;
        tick();
        check("t6_ready", 64'(task_ready), 64'(1));
        check("t6_idle", 64'(idle), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
